// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
// Holds the bit-level state encoding and the frame geometry constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } uart_tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_WORD_BYTES = 4;

endpackage

// File: rtl/uart_byte_tx.sv
// Single 8N1 frame serializer: baud counter, bit FSM and registered txd.
// ready is also high in the last stop-bit cycle so frames can chain gaplessly.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       txd
);

    localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W      = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t   state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       data_reg, data_next;
    logic             txd_reg, txd_next;
    logic             done_reg, done_next;
    logic             bit_end;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);
    assign ready   = (state_reg == IDLE) || ((state_reg == STOP_BIT) && bit_end);
    assign done    = done_reg;
    assign txd     = txd_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            data_reg     <= '0;
            txd_reg      <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            data_reg     <= data_next;
            txd_reg      <= txd_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg + 1'b1;
        bit_idx_next  = bit_idx_reg;
        data_next     = data_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                if (start) begin
                    state_next = START_BIT;
                    data_next  = data;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_next    = DATA_BITS;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = STOP_BIT;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    if (start) begin
                        state_next = START_BIT;
                        data_next  = data;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
                bit_idx_next  = '0;
            end
        endcase
    end

    // Line level is decided from the next state so txd stays a pure register.
    always_comb begin
        case (state_next)
            START_BIT: txd_next = 1'b0;
            DATA_BITS: txd_next = data_next[bit_idx_next];
            default:   txd_next = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word/byte UART transmitter: arbitrates requests, holds the remaining word
// bytes and feeds them LSB-first to the frame serializer without idle gaps.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        txd
);

    localparam logic [2:0] FRAMES_WORD = 3'(UART_WORD_BYTES);
    localparam logic [2:0] FRAMES_BYTE = 3'd1;

    logic [2:0]  frames_reg, frames_next;
    logic [23:0] word_reg, word_next;
    logic        word_accept;
    logic        byte_accept;
    logic        frame_ready;
    logic        frame_end;
    logic        next_frame;
    logic        frame_start;
    logic [7:0]  frame_byte;

    assign tx_ready    = (frames_reg == '0);
    assign word_accept = word_valid && tx_ready;
    assign byte_accept = byte_valid && !word_valid && tx_ready;

    // While busy the serializer only reports ready in the final stop-bit cycle.
    assign frame_end   = (frames_reg != '0) && frame_ready;
    assign next_frame  = frame_end && (frames_reg > FRAMES_BYTE);
    assign frame_start = word_accept || byte_accept || next_frame;

    always_comb begin
        if (word_accept) begin
            frame_byte = word_data[7:0];
        end else if (byte_accept) begin
            frame_byte = byte_data;
        end else begin
            frame_byte = word_reg[7:0];
        end
    end

    always_comb begin
        frames_next = frames_reg;
        word_next   = word_reg;
        if (word_accept) begin
            frames_next = FRAMES_WORD;
            word_next   = word_data[31:8];
        end else if (byte_accept) begin
            frames_next = FRAMES_BYTE;
        end else if (frame_end) begin
            frames_next = frames_reg - 1'b1;
            if (next_frame) begin
                word_next = {8'h00, word_reg[23:8]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frames_reg <= '0;
            word_reg   <= '0;
        end else begin
            frames_reg <= frames_next;
            word_reg   <= word_next;
        end
    end

    uart_byte_tx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_byte_tx (
        .clk   (clk),
        .reset (reset),
        .start (frame_start),
        .data  (frame_byte),
        .ready (frame_ready),
        .done  (tx_done),
        .txd   (txd)
    );

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a per-cycle waveform model of the serial line,
// a simple mid-bit sampling receiver, and directed literal expectations.
module tb_uart_word_tx;

    localparam int H   = 4;
    localparam int BIT = 2 * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] word_data = '0;
    logic        word_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_valid = 1'b0;
    logic        tx_ready;
    logic        tx_done;
    logic        txd;

    int vec_count = 0;
    int miscompares = 0;

    // Model: one expected line level per upcoming busy cycle.
    logic exp_q[$];
    logic exp_done = 1'b0;
    bit   armed = 1'b0;

    logic [7:0] rx_q[$];
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_shift = '0;

    logic wave [0:2047];

    uart_word_tx #(
        .CLK_PER_HALF_BIT(H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .word_data  (word_data),
        .word_valid (word_valid),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int k = 0; k < 10; k++) begin
            logic lvl;
            if (k == 0) lvl = 1'b0;
            else if (k == 9) lvl = 1'b1;
            else lvl = b[k-1];
            for (int c = 0; c < BIT; c++) exp_q.push_back(lvl);
        end
    endtask

    task automatic model_step();
        bit idle_before;
        idle_before = (exp_q.size() == 0);
        if (reset) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            if (!idle_before) void'(exp_q.pop_front());
            exp_done = !idle_before && (exp_q.size() == 0);
            if (idle_before && word_valid) begin
                for (int j = 0; j < 4; j++) push_frame(word_data[8*j +: 8]);
            end else if (idle_before && byte_valid) begin
                push_frame(byte_data);
            end
        end
    endtask

    task automatic compare_step();
        logic e_txd;
        e_txd = (exp_q.size() == 0) ? 1'b1 : exp_q[0];
        check("txd", 32'(txd), 32'(e_txd));
        check("tx_ready", 32'(tx_ready), 32'(exp_q.size() == 0));
        check("tx_done", 32'(tx_done), 32'(exp_done));
    endtask

    task automatic rx_step();
        int k;
        if (reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (txd == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % BIT) == H) begin
                k = rx_cnt / BIT;
                if (k >= 1 && k <= 8) begin
                    rx_shift[k-1] = txd;
                end else if (k == 9) begin
                    check("rx_stop_bit", 32'(txd), 32'd1);
                    rx_q.push_back(rx_shift);
                    rx_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic check_rx(input string name, input int idx, input logic [7:0] exp);
        if (idx < rx_q.size()) check(name, 32'(rx_q[idx]), 32'(exp));
        else check(name, 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check(name, 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        word_data = w;
        word_valid = 1'b1;
        wait_ready("accept_word_timeout");
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data = b;
        byte_valid = 1'b1;
        wait_ready("accept_byte_timeout");
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic measure(output int low, output int mid_dones, output logic end_done);
        low = 0;
        mid_dones = 0;
        while (!tx_ready && low < 2000) begin
            wave[low] = txd;
            if (tx_done) mid_dones++;
            low++;
            @(negedge clk);
        end
        if (low >= 2000) check("idle_timeout", 32'd0, 32'd1);
        end_done = tx_done;
    endtask

    initial begin
        int low, md, base, dcount;
        logic ed;
        logic [9:0] pat;
        logic [31:0] sent[$];
        logic [31:0] w;

        fork
            forever @(posedge clk) model_step();
            forever @(negedge clk) begin
                if (armed) compare_step();
                rx_step();
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_tx_done", 32'(tx_done), 32'd0);
        reset = 1'b0;
        armed = 1'b1;
        repeat (2) @(negedge clk);

        // Byte 0x99: literal line pattern sampled mid-bit
        base = rx_q.size();
        send_byte(8'h99);
        check("byte_start_txd", 32'(txd), 32'd0);
        measure(low, md, ed);
        pat = 10'b1100110010;
        for (int k = 0; k < 10; k++) check("byte99_bit", 32'(wave[BIT*k + H]), 32'(pat[k]));
        check("byte99_ready_low", 32'(low), 32'd80);
        check("byte99_mid_done", 32'(md), 32'd0);
        check("byte99_done", 32'(ed), 32'd1);
        repeat (4) @(negedge clk);
        check_rx("byte99_rx", base, 8'h99);

        // Word 0xDEADBEEF, data bus scrambled after acceptance
        base = rx_q.size();
        send_word(32'hDEADBEEF);
        word_data = 32'h0;
        measure(low, md, ed);
        check("word_ready_low", 32'(low), 32'd320);
        check("word_done", 32'(ed), 32'd1);
        check("word_gap_stop1", 32'(wave[79]), 32'd1);
        check("word_gap_start2", 32'(wave[80]), 32'd0);
        check("word_gap_start4", 32'(wave[240]), 32'd0);
        repeat (4) @(negedge clk);
        check_rx("word_rx0", base,     8'hEF);
        check_rx("word_rx1", base + 1, 8'hBE);
        check_rx("word_rx2", base + 2, 8'hAD);
        check_rx("word_rx3", base + 3, 8'hDE);

        // Word and byte requested together: word first, byte on the done cycle
        base = rx_q.size();
        word_data = 32'h12345678;
        byte_data = 8'hAA;
        word_valid = 1'b1;
        byte_valid = 1'b1;
        wait_ready("accept_both_timeout");
        @(negedge clk);
        word_valid = 1'b0;
        measure(low, md, ed);
        check("both_word_low", 32'(low), 32'd320);
        check("both_word_done", 32'(ed), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        check("both_byte_ready", 32'(tx_ready), 32'd0);
        check("both_byte_start", 32'(txd), 32'd0);
        measure(low, md, ed);
        check("both_byte_low", 32'(low), 32'd80);
        check("both_byte_done", 32'(ed), 32'd1);
        repeat (4) @(negedge clk);
        check_rx("both_rx0", base,     8'h78);
        check_rx("both_rx1", base + 1, 8'h56);
        check_rx("both_rx2", base + 2, 8'h34);
        check_rx("both_rx3", base + 3, 8'h12);
        check_rx("both_rx4", base + 4, 8'hAA);

        // Reset during data bit 3 of the second frame
        send_word(32'hCAFEF00D);
        repeat (80 + 32 + 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_txd", 32'(txd), 32'd1);
        check("mid_reset_ready", 32'(tx_ready), 32'd1);
        check("mid_reset_done", 32'(tx_done), 32'd0);
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx_done) dcount++;
            @(negedge clk);
        end
        check("mid_reset_no_done", 32'(dcount), 32'd0);
        base = rx_q.size();
        send_byte(8'h55);
        measure(low, md, ed);
        check("after_reset_low", 32'(low), 32'd80);
        check("after_reset_done", 32'(ed), 32'd1);
        repeat (4) @(negedge clk);
        check_rx("after_reset_rx", base, 8'h55);

        // Loopback of random words through the bench receiver
        base = rx_q.size();
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            sent.push_back(w);
            send_word(w);
        end
        wait_ready("loopback_idle_timeout");
        repeat (10) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            w = 32'hFFFF_FFFF;
            if (base + 4*i + 3 < rx_q.size())
                w = {rx_q[base+4*i+3], rx_q[base+4*i+2], rx_q[base+4*i+1], rx_q[base+4*i]};
            else
                w = ~sent[i];
            check("loopback_word", w, sent[i]);
        end

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Transmit-side counterpart of the word-oriented UART receiver used by the bootloader. It accepts either a 32-bit word or a single byte through a valid/ready handshake and serializes it onto `txd` as standard 8N1 frames, sending words as four back-to-back frames, least-significant byte first. It sits between the core's host-link logic, which sends acknowledge bytes such as 0x99 and 0xAA and dumps result words, and the board TX pin.

## Interface
- `CLK_PER_HALF_BIT`, default 5208: clock cycles per half UART bit. One bit period is `2*CLK_PER_HALF_BIT` cycles.
- `clk`  in  1  system clock, the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `word_data`  in  32  word to send.
- `word_valid`  in  1  word request; held high until accepted.
- `byte_data`  in  8  single byte to send.
- `byte_valid`  in  1  byte request; held high until accepted.
- `tx_ready`  out  1  high while idle and able to accept a request.
- `tx_done`  out  1  one-cycle pulse after the last stop bit of a request completes.
- `txd`  out  1  serial line; idles high.

## Operation
- Acceptance:
  - A word is accepted when `word_valid & tx_ready`.
  - A byte is accepted when `byte_valid & ~word_valid & tx_ready`.
  - If both are valid in the same cycle, the word wins. The byte stays pending and is accepted on the next idle cycle.
- On acceptance:
  - Latch the data.
  - Set the frames remaining to 4 for a word, or 1 for a byte.
  - Drop `tx_ready`.
- Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1).
- Word byte order: `word_data[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- Consecutive frames of one word follow each other with no idle gap: the next start bit immediately follows the previous stop bit.
- States:
  - `IDLE`: `txd`=1, `tx_ready`=1. On acceptance go to `START_BIT`.
  - `START_BIT`: `txd`=0 for one bit period, then go to `DATA_BITS`.
  - `DATA_BITS`: `txd` = current bit; bit index 0..7. After bit 7, go to `STOP_BIT`.
  - `STOP_BIT`: `txd`=1 for one bit period. Then:
    - if frames remaining > 1: decrement the count, shift the next byte in, go to `START_BIT`;
    - else: pulse `tx_done` and go to `IDLE`.
- Counters:
  - Baud counter counts 0..`2*CLK_PER_HALF_BIT-1` and wraps at each bit boundary. Width is `$clog2(2*CLK_PER_HALF_BIT)`.
  - Bit index: 3 bits. Frames remaining: 3 bits.
- Input data is sampled only at acceptance. Changes to `word_data` or `byte_data` while busy have no effect.
- Reset (also mid-frame):
  - The frame is abandoned.
  - The next cycle: `txd`=1, `tx_ready`=1, `tx_done`=0, state `IDLE`, all counters 0.
  - No partial frame is ever resumed.

## Timing
- Output values during and right after reset: `txd`=1, `tx_ready`=1, `tx_done`=0.
- Acceptance at clock edge N:
  - `tx_ready`=0 and `txd`=0 from cycle N+1.
  - The start bit spans cycles N+1 .. N+2H, where H = `CLK_PER_HALF_BIT`.
- Duration:
  - One frame is 20H cycles.
  - A byte request holds `tx_ready` low for exactly 20H cycles.
  - A word request holds `tx_ready` low for exactly 80H cycles.
- `tx_done` is high for one cycle, the first cycle after the last stop bit; `tx_ready` is 1 in that same cycle.
- A new request may be accepted in that same cycle, giving a back-to-back start with zero idle bits between requests.
- `txd` is a registered output with no combinational path from the inputs.

## Structure
- Shared package `uart_pkg`: state enum `uart_tx_state_t` (`IDLE`, `START_BIT`, `DATA_BITS`, `STOP_BIT`) and the constants `UART_DATA_BITS`=8 and `UART_WORD_BYTES`=4. The receive side uses the same package.
- Sub-module `uart_byte_tx` (baud counter, bit FSM, `txd` register), with a start/byte in and done/ready out.
- The top level adds request arbitration, the word shift register and the frame count.

## Test plan
All scenarios use `CLK_PER_HALF_BIT`=4, i.e. an 8-cycle bit period.
- Byte 0x99 via `byte_valid` -> `txd` pattern 0,1,0,0,1,1,0,0,1,1, each level 8 cycles; `tx_ready` low for 80 cycles; one `tx_done` pulse.
- Word 0xDEADBEEF -> frames carry 0xEF, 0xBE, 0xAD, 0xDE in that order; no idle gap between frames; `tx_ready` low for 320 cycles.
- `word_valid` and `byte_valid` both asserted with word 0x12345678 and byte 0xAA -> the word is sent first; 0xAA starts on the `tx_done` cycle; the line never idles between the two requests.
- `reset` pulsed during bit 3 of the second frame of a word -> the next cycle `txd`=1 and `tx_ready`=1; no `tx_done`; a fresh byte 0x55 then transmits cleanly.
- `word_data` changed mid-transmission -> the serialized bits match the value latched at acceptance.
- A receiver loopback (the existing `uart_word` receiver on `txd`) of 100 random words -> every received word equals the word sent.
